// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: request and response channels of alu_dispatch (master = decode/writeback side, slave = alu_dispatch); rsp_zero only with ALU_DISPATCH_ZERO_FLAG_EN
interface alu_dispatch_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W = 3
);
  logic req_valid;
  logic req_ready;
  logic [2:0] req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0] req_dst;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_dst;
  logic rsp_err;
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
  logic rsp_zero;
`endif
  modport master (
    output req_valid, req_op, req_a, req_b, req_dst, rsp_ready,
    input req_ready, rsp_valid, rsp_result, rsp_dst, rsp_err
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
    , rsp_zero
`endif
  );
  modport slave (
    input req_valid, req_op, req_a, req_b, req_dst, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_dst, rsp_err
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
    , rsp_zero
`endif
  );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch: FIFO-buffered request initiator for the 16-bit combinational ALU. Ports: clk, rst_n (sync active-low), bus (alu_dispatch_if.slave: req/rsp channels), alu_op/alu_a/alu_b (registered ALU inputs), alu_result (ALU output). Macro ALU_DISPATCH_ZERO_FLAG_EN adds rsp_zero.
module alu_dispatch #(
  parameter int DATA_W = 16,
  parameter int TAG_W = 3,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  alu_dispatch_if.slave bus,
  output logic [2:0] alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] mem_op [DEPTH];
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [TAG_W-1:0] mem_dst [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, pop_legal;
  // ready comes from the registered count only, so a same-cycle pop never frees a slot early
  assign bus.req_ready = rst_n && (count < (AW+1)'(DEPTH));
  assign push = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = state_q == RESP;
  assign pop_legal = pop && mem_op[rd_ptr] != 3'b111;
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    if (state_q == ISSUE) state_d = RESP;
    else if (state_q == IDLE || bus.rsp_ready) begin
      pop = count != '0;
      state_d = !pop ? IDLE : (mem_op[rd_ptr] == 3'b111 ? RESP : ISSUE);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr] <= bus.req_op;
      mem_a[wr_ptr] <= bus.req_a;
      mem_b[wr_ptr] <= bus.req_b;
      mem_dst[wr_ptr] <= bus.req_dst;
    end
  end
  // an illegal pop completes immediately with result 0 and err set, leaving the ALU inputs untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_op <= '0;
      alu_a <= '0;
      alu_b <= '0;
      bus.rsp_result <= '0;
      bus.rsp_dst <= '0;
      bus.rsp_err <= 1'b0;
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
      bus.rsp_zero <= 1'b0;
`endif
    end else begin
      if (pop_legal) begin
        alu_op <= mem_op[rd_ptr];
        alu_a <= mem_a[rd_ptr];
        alu_b <= mem_b[rd_ptr];
      end
      if (pop) begin
        bus.rsp_dst <= mem_dst[rd_ptr];
        bus.rsp_result <= '0;
        bus.rsp_err <= !pop_legal;
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
        bus.rsp_zero <= 1'b0;
`endif
      end
      if (state_q == ISSUE) begin
        bus.rsp_result <= alu_result;
        bus.rsp_err <= 1'b0;
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
        bus.rsp_zero <= alu_result == '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: randomized and directed self-checking bench for alu_dispatch against a queue-based reference model
module tb_alu_dispatch;
  localparam int DATA_W = 16;
  localparam int TAG_W = 3;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  int n_checks = 0;
  int n_err = 0;
  typedef struct packed {
    logic [15:0] result;
    logic [2:0] dst;
    logic err;
    logic zero;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t e;
  always #5 clk = ~clk;
  alu_dispatch_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
  alu_dispatch #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_result(alu_result)
  );
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a & b;
      3'd2: return b - a;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b;
      3'd6: return a >> b;
      default: return 16'hDEAD;
    endcase
  endfunction
  always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);
  function automatic rsp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] dst);
    rsp_t r;
    r.err = op == 3'b111;
    r.result = r.err ? 16'h0 : alu_fn(op, a, b);
    r.dst = dst;
    r.zero = !r.err && r.result == 16'h0;
    return r;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) exp_q.delete();
    else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rsp_result", bus.rsp_result, e.result);
          check("rsp_dst", bus.rsp_dst, e.dst);
          check("rsp_err", bus.rsp_err, e.err);
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
          check("rsp_zero", bus.rsp_zero, e.zero);
`endif
        end
      end
      if (bus.req_valid && bus.req_ready) exp_q.push_back(model(bus.req_op, bus.req_a, bus.req_b, bus.req_dst));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] dst);
    logic acc;
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_dst = dst;
    do begin
      acc = bus.req_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 0, 1);
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", bus.rsp_valid, 0);
  endtask
  initial begin
    logic acc;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_dst = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 0);
    check("rst_rsp", {bus.rsp_result, bus.rsp_dst, bus.rsp_err}, 0);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", bus.req_ready, 1);
    tick();
    send(3'd0, 16'h0005, 16'h0003, 3'd2);
    check("add_lat_n", bus.rsp_valid, 0);
    tick();
    check("add_lat_n1", bus.rsp_valid, 0);
    check("add_alu", {alu_op, alu_a, alu_b}, {3'd0, 16'h0005, 16'h0003});
    tick();
    check("add_valid", bus.rsp_valid, 1);
    check("add_result", bus.rsp_result, 16'h0008);
    check("add_dst", bus.rsp_dst, 2);
    check("add_err", bus.rsp_err, 0);
    tick();
    check("add_hold", {bus.rsp_valid, bus.rsp_result}, {1'b1, 16'h0008});
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("add_done", bus.rsp_valid, 0);
    send(3'd7, 16'hFFFF, 16'h0001, 3'd5);
    check("ill_lat_n", bus.rsp_valid, 0);
    tick();
    check("ill_valid", bus.rsp_valid, 1);
    check("ill_rsp", {bus.rsp_result, bus.rsp_dst, bus.rsp_err}, {16'h0, 3'd5, 1'b1});
    check("ill_alu_kept", {alu_op, alu_a, alu_b}, {3'd0, 16'h0005, 16'h0003});
    bus.rsp_ready = 1'b1;
    send(3'd2, 16'd3, 16'd10, 3'd1);
    send(3'd5, 16'd1, 16'd4, 3'd3);
    tick();
    check("ord_first", {bus.rsp_valid, bus.rsp_result}, {1'b1, 16'h0007});
    tick();
    check("ord_gap", bus.rsp_valid, 0);
    tick();
    check("ord_second", {bus.rsp_valid, bus.rsp_result, bus.rsp_dst}, {1'b1, 16'h0010, 3'd3});
    tick();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", bus.req_ready, 1);
      send(3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom_range(0, 20)), 3'(i));
    end
    check("full_ready", bus.req_ready, 0);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold", {bus.rsp_valid, bus.req_ready}, 2'b10);
    end
    bus.req_valid = 1'b0;
    check("full_queued", exp_q.size(), 5);
    bus.rsp_ready = 1'b1;
    send(3'd1, 16'hF0F0, 16'h3C3C, 3'd6);
    drain();
    bus.rsp_ready = 1'b0;
    send(3'd0, 16'd1, 16'd2, 3'd1);
    send(3'd3, 16'd4, 16'd8, 3'd2);
    send(3'd4, 16'd7, 16'd7, 3'd3);
    tick();
    tick();
    check("pre_rst_valid", bus.rsp_valid, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_ready", bus.req_ready, 0);
    check("mid_rst_valid", bus.rsp_valid, 0);
    check("mid_rst_alu", {alu_op, alu_a, alu_b}, 0);
    check("mid_rst_rsp", {bus.rsp_result, bus.rsp_dst, bus.rsp_err}, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", bus.req_ready, 1);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_quiet", bus.rsp_valid, 0);
    end
`ifdef ALU_DISPATCH_ZERO_FLAG_EN
    bus.rsp_ready = 1'b0;
    send(3'd4, 16'h1234, 16'h1234, 3'd4);
    tick();
    tick();
    check("zero_set", {bus.rsp_valid, bus.rsp_result, bus.rsp_zero}, {1'b1, 16'h0, 1'b1});
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    send(3'd0, 16'd1, 16'd1, 3'd5);
    tick();
    tick();
    check("zero_clr", {bus.rsp_valid, bus.rsp_result, bus.rsp_zero}, {1'b1, 16'h2, 1'b0});
    drain();
`endif
    for (int i = 0; i < 400; i++) begin
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      acc = bus.req_valid && bus.req_ready;
      if (acc || !bus.req_valid) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_op = 3'($urandom);
        bus.req_a = $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom);
        bus.req_b = bus.req_op inside {3'd5, 3'd6} ? 16'($urandom_range(0, 17)) : 16'($urandom);
        bus.req_dst = 3'($urandom);
      end
      tick();
    end
    bus.req_valid = 1'b0;
    drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Request-side initiator for the CORG 16-bit combinational ALU. Buffers operation requests from the decode stage in a small FIFO, then drives them one at a time onto the ALU's operation and operand inputs. It samples the ALU result one cycle later and returns it with its destination tag over a valid/ready response channel. Sits between instruction decode and register-file writeback.

## Interface
Parameters:
- `DATA_W`, 16, operand/result width
- `TAG_W`, 3, destination-register tag width
- `DEPTH`, 4, request FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  FIFO can accept
- `req_op`  in  3  ALU opcode
- `req_a`, `req_b`  in  DATA_W  operands
- `req_dst`  in  TAG_W  destination tag
- `alu_op`  out  3  to ALU operation input (registered)
- `alu_a`, `alu_b`  out  DATA_W  to ALU operand inputs (registered)
- `alu_result`  in  DATA_W  from ALU (combinational)
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts
- `rsp_result`  out  DATA_W  captured result
- `rsp_dst`  out  TAG_W  tag of result
- `rsp_err`  out  1  opcode was illegal (111)
- `rsp_zero`  out  1  result == 0 (only with `ALU_DISPATCH_ZERO_FLAG_EN`)

## Operation
- Opcode map:
  - 000 add
  - 001 and
  - 010 sub (b − a)
  - 011 or
  - 100 xor
  - 101 sll
  - 110 srl
  - 111 illegal
- Push: `req_valid && req_ready` writes {op,a,b,dst} at FIFO tail.
- `req_ready` = (count < DEPTH), derived from registered count. A pop in the same cycle does not raise it.
- FSM states:
  - IDLE: if FIFO non-empty, pop head.
    - Legal op: load `alu_op/alu_a/alu_b` and latch dst, go to ISSUE.
    - Op 111: do not touch ALU ports. Load `rsp_result`=0, `rsp_err`=1, go to RESP.
  - ISSUE: ALU inputs stable for the full cycle. At the edge, capture `alu_result` into `rsp_result`, set `rsp_err`=0, go to RESP.
  - RESP: `rsp_valid`=1. Outputs held stable until `rsp_ready`.
    - On handshake with FIFO non-empty: pop directly, same rules as IDLE.
    - On handshake with FIFO empty: go to IDLE.
- `alu_*` registers change only on a legal pop; otherwise they hold their last value.
- Results are returned strictly in request order.
- No arithmetic is done locally. Width is DATA_W throughout; overflow and carry are dropped by the ALU.

## Timing
- Reset (rst_n=0 at an edge):
  - FIFO emptied, FSM to IDLE.
  - `req_ready`=0 during reset, 1 from the first cycle after release.
  - `alu_op`/`alu_a`/`alu_b`/`rsp_result`/`rsp_dst` = 0.
  - `rsp_valid`/`rsp_err`/`rsp_zero` = 0.
  - In-flight and queued requests are dropped, including reset asserted in ISSUE or RESP.
- Latency from push at edge N to `rsp_valid` (empty FIFO, IDLE):
  - Legal op: pop at N+1, capture at N+2, so `rsp_valid` is high after edge N+2.
  - Illegal op: `rsp_valid` is high after edge N+1.
- Sustained throughput: one legal result per 2 cycles with `rsp_ready` held high.
- Full FIFO: `req_ready`=0. A request held with `req_valid` is accepted the cycle after a pop lowers the count.
- Push into empty FIFO while in IDLE: the entry is visible to the pop one cycle later. There is no fall-through.
- Back-pressure: with `rsp_ready`=0, RESP holds indefinitely and the FIFO fills to DEPTH.

## Configuration
- `ALU_DISPATCH_ZERO_FLAG_EN` defined:
  - `rsp_zero` port exists.
  - Registered alongside `rsp_result`: 1 iff the captured result is 0 and `rsp_err`=0.
  - Reset value 0.
- Undefined: port and logic are absent. All other behaviour is identical.

## Test plan
- Single add: push op=000, a=0x0005, b=0x0003, dst=2 at edge N; ALU model returns a+b. Expect `rsp_valid` after N+2 with result 0x0008, dst=2, err=0.
- Sub ordering: push 010, a=3, b=10, then 101, a=1, b=4, `rsp_ready`=1. Expect 0x0007, then 0x0010, in order, 2 cycles apart.
- Illegal op: push 111, a=0xFFFF, b=1. Expect `rsp_valid` after N+1 with result 0, err=1, and `alu_*` unchanged.
- Back-pressure/full: hold `rsp_ready`=0 and push 5 requests with DEPTH=4. Expect `req_ready`=0 after the 4th is queued; release `rsp_ready` and all 5 results return in order.
- Reset mid-RESP: assert `rsp_ready`=0 with 3 queued, then pull `rst_n` low for one edge. Expect all outputs 0, no further `rsp_valid`, and `req_ready`=1 the cycle after release.
- Zero flag (macro on): push xor a=0x1234, b=0x1234. Expect result 0 and `rsp_zero`=1; the next add of 1+1 gives `rsp_zero`=0.
